// File: rtl/accel_pkg.sv
// Shared constants and state types for the accelerator host link.
package accel_pkg;

    // Command bytes decoded by the host command handler.
    localparam logic [7:0] CMD_LOAD_A = 8'd0;
    localparam logic [7:0] CMD_LOAD_B = 8'd1;
    localparam logic [7:0] CMD_COMM   = 8'd2;

    // Default sizing of the result vector and UART bit timing.
    localparam int DEFAULT_NBYTES       = 1024;
    localparam int DEFAULT_ADDR_W       = 10;
    localparam int DEFAULT_CLKS_PER_BIT = 100;

    // Control FSM that walks the result memory.
    typedef enum logic [2:0] {
        CTRL_IDLE,
        CTRL_FETCH,
        CTRL_WAIT,
        CTRL_LOAD,
        CTRL_SEND,
        CTRL_DONE
    } tx_ctrl_state_t;

    // Per-frame serializer states.
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_bit_state_t;

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART serializer; interface mirrors uart_rx for loopback use.
module uart_tx
    import accel_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       Clock,
    input  logic       reset,
    input  logic       Tx_DV,
    input  logic [7:0] Tx_Byte,
    output logic       Tx_Serial,
    output logic       Tx_Done
);

    localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    tx_bit_state_t    bit_state, bit_state_nxt;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       tx_shift, tx_shift_nxt;
    logic             serial_nxt;
    logic             bit_end;

    assign bit_end = (baud_cnt == LAST_CNT);
    // Frame end is flagged on the last cycle of the stop bit.
    assign Tx_Done = (bit_state == TX_STOP) && bit_end;

    // State register; the line value is a flop so Tx_Serial has no input path.
    always_ff @(posedge Clock) begin
        if (reset) begin
            bit_state <= TX_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            tx_shift  <= '0;
            Tx_Serial <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            bit_state <= bit_state_nxt;
            baud_cnt  <= baud_cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            tx_shift  <= tx_shift_nxt;
            Tx_Serial <= serial_nxt;
        end
    end

    // Next-state logic: each bit lasts CLKS_PER_BIT cycles, data shifted out LSB first.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        bit_state_nxt = bit_state;
        baud_cnt_nxt  = baud_cnt + CNT_W'(1);
        bit_idx_nxt   = bit_idx;
        tx_shift_nxt  = tx_shift;
        serial_nxt    = Tx_Serial;
        unique case (bit_state)
            TX_IDLE: begin
                baud_cnt_nxt = '0;
                bit_idx_nxt  = '0;
                serial_nxt   = 1'b1;
                if (Tx_DV) begin
                    tx_shift_nxt  = Tx_Byte;
                    serial_nxt    = 1'b0;
                    bit_state_nxt = TX_START;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    baud_cnt_nxt  = '0;
                    serial_nxt    = tx_shift[0];
                    bit_state_nxt = TX_DATA;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    baud_cnt_nxt = '0;
                    if (bit_idx == 3'd7) begin
                        serial_nxt    = 1'b1;
                        bit_state_nxt = TX_STOP;
                    end else begin
                        bit_idx_nxt  = bit_idx + 3'd1;
                        tx_shift_nxt = tx_shift >> 1;
                        serial_nxt   = tx_shift[1];
                    end
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    baud_cnt_nxt  = '0;
                    bit_state_nxt = TX_IDLE;
                end
            end
            default: bit_state_nxt = TX_IDLE;
        endcase
    end

endmodule

// File: rtl/result_uart_tx.sv
// Streams NBYTES of result memory to the host as back-to-back 8N1 frames.
module result_uart_tx
    import accel_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int NBYTES       = DEFAULT_NBYTES,
    parameter int ADDR_W       = DEFAULT_ADDR_W
) (
    input  logic              Clock,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              Tx_Serial,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NBYTES - 1);

    tx_ctrl_state_t    state, state_nxt;
    logic [ADDR_W-1:0] rd_addr_nxt;
    logic              busy_nxt;
    logic              done_nxt;
    logic              tx_dv;
    logic              tx_done;

    // Control state and registered outputs.
    always_ff @(posedge Clock) begin
        if (reset) begin
            state   <= CTRL_IDLE;
            rd_addr <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            rd_addr <= rd_addr_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

    // Walk addresses 0..NBYTES-1, one frame per byte, then pulse done.
    always_comb begin
        state_nxt   = state;
        rd_addr_nxt = rd_addr;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        tx_dv       = 1'b0;
        unique case (state)
            CTRL_IDLE: begin
                busy_nxt = 1'b0;
                if (start) begin
                    rd_addr_nxt = '0;
                    busy_nxt    = 1'b1;
                    state_nxt   = CTRL_FETCH;
                end
            end
            CTRL_FETCH: state_nxt = CTRL_WAIT;
            CTRL_WAIT: begin
                // Read data is valid here; the serializer latches it on the edge
                // into LOAD, so the start bit leaves two cycles after FETCH.
                tx_dv     = 1'b1;
                state_nxt = CTRL_LOAD;
            end
            CTRL_LOAD: state_nxt = CTRL_SEND;
            CTRL_SEND: begin
                if (tx_done) begin
                    if (rd_addr == LAST_ADDR) begin
                        done_nxt    = 1'b1;
                        busy_nxt    = 1'b0;
                        rd_addr_nxt = '0;
                        state_nxt   = CTRL_DONE;
                    end else begin
                        rd_addr_nxt = rd_addr + ADDR_W'(1);
                        state_nxt   = CTRL_FETCH;
                    end
                end
            end
            CTRL_DONE: state_nxt = CTRL_IDLE;
            default:   state_nxt = CTRL_IDLE;
        endcase
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .Clock    (Clock),
        .reset    (reset),
        .Tx_DV    (tx_dv),
        .Tx_Byte  (rd_data),
        .Tx_Serial(Tx_Serial),
        .Tx_Done  (tx_done)
    );

endmodule

// File: tb/tb_result_uart_tx.sv
// Self-checking bench for result_uart_tx: frame-level model plus directed scenarios.
module tb_result_uart_tx;

    localparam int C  = 4;
    localparam int NB = 4;
    localparam int AW = 3;
    localparam int P  = 10 * C + 2;

    logic          Clock = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          Tx_Serial;
    logic          busy;
    logic          done;

    logic [7:0] mem [NB];
    int         pass_cnt  = 0;
    int         total_cnt = 0;
    int         edge_cnt  = 0;
    bit         check_en  = 1'b0;
    bit         m_act     = 1'b0;
    int         m_t0      = 0;
    int         max_addr  = 0;
    logic       trace [64];
    logic [7:0] rx_q [$];
    bit         rx_on = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_sh = '0;

    result_uart_tx #(
        .CLKS_PER_BIT(C),
        .NBYTES      (NB),
        .ADDR_W      (AW)
    ) dut (
        .Clock    (Clock),
        .reset    (reset),
        .start    (start),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .Tx_Serial(Tx_Serial),
        .busy     (busy),
        .done     (done)
    );

    always #5 Clock = ~Clock;

    // Registered-read memory.
    always @(posedge Clock) rd_data <= mem[rd_addr];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_cnt++;
        if (actual === expected) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edge_cnt);
    endtask

    // Transfer tracker: when a transfer was accepted, and when it is over.
    always @(posedge Clock) begin
        edge_cnt++;
        if (reset) m_act = 1'b0;
        else if (m_act) begin
            if (edge_cnt - m_t0 == NB * P + 1) m_act = 1'b0;
        end else if (start) begin
            m_act = 1'b1;
            m_t0  = edge_cnt;
        end
    end

    // Per-cycle comparison against the frame timing rules.
    always @(negedge Clock) begin
        int n, k, m, j, e_addr;
        logic e_line, e_busy, e_done;
        if (check_en) begin
            e_line = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_addr = 0;
            if (m_act) begin
                n = edge_cnt - m_t0;
                if (n < NB * P) begin
                    k = n / P;
                    m = n % P;
                    e_busy = 1'b1;
                    e_addr = k;
                    if (m >= 2) begin
                        j = (m - 2) / C;
                        if (j == 0) e_line = 1'b0;
                        else if (j <= 8) e_line = mem[k][j-1];
                    end
                end else if (n == NB * P) begin
                    e_done = 1'b1;
                end
            end
            check("model_tx_serial", Tx_Serial, e_line);
            check("model_busy", busy, e_busy);
            check("model_done", done, e_done);
            check("model_rd_addr", rd_addr, e_addr);
            if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
        end
    end

    // Loopback receiver: mid-bit sampling of each 8N1 frame.
    always @(negedge Clock) begin
        if (reset) rx_on = 1'b0;
        else if (!rx_on) begin
            if (Tx_Serial === 1'b0) begin
                rx_on  = 1'b1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt == C / 2 + 9 * C) begin
                rx_on = 1'b0;
                if (Tx_Serial === 1'b1) rx_q.push_back(rx_sh);
            end else if (rx_cnt >= C / 2 + C && (rx_cnt - C / 2) % C == 0) begin
                rx_sh = {Tx_Serial, rx_sh[7:1]};
            end
        end
    end

    task automatic pulse_start(output int e0);
        @(posedge Clock);
        #2 start = 1'b1;
        @(posedge Clock);
        #1 e0 = edge_cnt;
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int e0, output int done_edge, output int busy_cycles);
        bit seen;
        seen = 1'b0;
        busy_cycles = 0;
        done_edge = -1;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge Clock);
            if (edge_cnt - e0 >= 0 && edge_cnt - e0 < 64) trace[edge_cnt - e0] = Tx_Serial;
            if (busy === 1'b1) busy_cycles++;
            if (done === 1'b1) begin
                seen = 1'b1;
                done_edge = edge_cnt;
            end
        end
        check("done_seen", seen, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int e0, e1, de, bc, busy_at, low_at, addr_at, cnt;
        logic [7:0] exp_bytes [NB];
        logic exp_a5 [10];

        mem       = '{8'hA5, 8'h3C, 8'h00, 8'hFF};
        exp_bytes = '{8'hA5, 8'h3C, 8'h00, 8'hFF};
        exp_a5    = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge Clock);
        check_en = 1'b1;
        #2 reset = 1'b0;
        @(negedge Clock);
        check("reset_tx_serial", Tx_Serial, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_rd_addr", rd_addr, 0);

        // Single transfer with bit-level trace of the first frame.
        rx_q.delete();
        pulse_start(e0);
        wait_done(e0, de, bc);
        check("t1_done_cycle", de - e0, 168);
        check("t1_busy_cycles", bc, 168);
        check("t1_rx_count", rx_q.size(), NB);
        for (int i = 0; i < NB; i++) check("t1_rx_byte", rx_q[i], exp_bytes[i]);
        check("t1_gap_before_start", {trace[0], trace[1]}, 2'b11);
        for (int b = 0; b < 10; b++)
            check("t1_a5_bit", {trace[2+4*b], trace[3+4*b], trace[4+4*b], trace[5+4*b]},
                  {4{exp_a5[b]}});
        check("t1_max_addr", max_addr, NB - 1);

        // Start re-pulsed mid-transfer and held through DONE.
        rx_q.delete();
        pulse_start(e0);
        repeat (50) @(posedge Clock);
        #2 start = 1'b1;
        wait_done(e0, de, bc);
        check("t3_done_cycle", de - e0, 168);
        check("t3_rx_count", rx_q.size(), NB);
        rx_q.delete();
        busy_at = -1; low_at = -1; addr_at = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge Clock);
            if (busy === 1'b1 && busy_at < 0) begin
                busy_at = i;
                addr_at = int'(rd_addr);
            end
            if (Tx_Serial === 1'b0 && low_at < 0) low_at = i;
        end
        start = 1'b0;
        check("t3_restart_busy_offset", busy_at, 2);
        check("t3_restart_addr", addr_at, 0);
        check("t3_restart_start_bit_offset", low_at, 4);
        e1 = de + 2;
        wait_done(e1, de, bc);
        check("t3_second_done_cycle", de - e1, 168);
        check("t3_second_rx_count", rx_q.size(), NB);
        check("t3_second_rx_first", rx_q[0], 8'hA5);
        cnt = 0;
        repeat (60) begin
            @(negedge Clock);
            if (busy !== 1'b0 || done !== 1'b0) cnt++;
        end
        check("t3_no_third_transfer", cnt, 0);

        // Reset in the middle of a data bit of byte 2.
        rx_q.delete();
        pulse_start(e0);
        repeat (95) @(posedge Clock);
        @(negedge Clock);
        check("t4_pre_reset_line", Tx_Serial, 1'b0);
        check("t4_pre_reset_addr", rd_addr, 2);
        #1 reset = 1'b1;
        @(posedge Clock);
        #2 reset = 1'b0;
        @(negedge Clock);
        check("t4_reset_tx_serial", Tx_Serial, 1'b1);
        check("t4_reset_busy", busy, 1'b0);
        check("t4_reset_rd_addr", rd_addr, 0);
        check("t4_reset_done", done, 1'b0);
        cnt = 0;
        repeat (100) begin
            @(negedge Clock);
            if (done !== 1'b0) cnt++;
        end
        check("t4_no_done_after_reset", cnt, 0);
        rx_q.delete();
        pulse_start(e0);
        wait_done(e0, de, bc);
        check("t4_done_cycle", de - e0, 168);
        check("t4_rx_count", rx_q.size(), NB);
        for (int i = 0; i < NB; i++) check("t4_rx_byte", rx_q[i], exp_bytes[i]);
        check("final_max_addr", max_addr, NB - 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
